// File: rtl/auto_player.sv
// auto_player: song-playback sequencer. Walks a song held in an external
// synchronous ROM, drives the note mask / octave shift for each entry's
// duration, inserts a silent articulation gap, and supports start,
// pause/resume, stop and loop control.
module auto_player #(
  parameter int TICK_DIV  = 1_000_000,
  parameter int GAP_TICKS = 2,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
  input  logic              loop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [7:0]        notes,
  output logic [1:0]        shift,
  output logic              busy,
  output logic              paused,
  output logic              done
);

  localparam int                CYC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(TICK_DIV - 1);
  localparam logic [5:0]        GAP_LAST = 6'(GAP_TICKS - 1);
  localparam bit                HAS_GAP  = (GAP_TICKS > 0);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_PLAY, S_GAP, S_PAUSED
  } state_t;

  state_t            state_q, state_d;
  state_t            ret_q, ret_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [5:0]        tick_q, tick_d;
  logic [5:0]        dur_q, dur_d;
  logic [7:0]        nlat_q, nlat_d;
  logic [1:0]        shift_q, shift_d;
  logic [7:0]        notes_q;
  logic              busy_q, paused_q, done_q, done_d;

  logic tick_end, play_exp, gap_exp, advance, finish;

  assign tick_end = (cyc_q == CYC_LAST);
  assign play_exp = (state_q == S_PLAY) && tick_end && (tick_q == dur_q - 6'd1);
  assign gap_exp  = (state_q == S_GAP) && tick_end && (tick_q == GAP_LAST);

  // Next-state logic: sequencing, counters, end-of-song handling, overrides.
  // A pause arriving on the very cycle a note or gap expires is dropped so the
  // sequencer never parks in PAUSED with an already-exhausted count.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    addr_d  = addr_q;
    cyc_d   = cyc_q;
    tick_d  = tick_q;
    dur_d   = dur_q;
    nlat_d  = nlat_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;

    // cycles of PLAY/GAP always count, including the cycle a pause is sampled
    if (state_q == S_PLAY || state_q == S_GAP) begin
      if (tick_end) begin
        cyc_d  = '0;
        tick_d = tick_q + 6'd1;
      end else begin
        cyc_d  = cyc_q + CYC_W'(1);
      end
    end

    case (state_q)
      S_IDLE: ;
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (rom_data[5:0] == 6'd0) begin
          finish = 1'b1;
        end else begin
          nlat_d  = rom_data[15:8];
          shift_d = rom_data[7:6];
          dur_d   = rom_data[5:0];
          cyc_d   = '0;
          tick_d  = '0;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (play_exp) begin
          cyc_d  = '0;
          tick_d = '0;
          if (HAS_GAP) state_d = S_GAP;
          else         advance = 1'b1;
        end else if (pause) begin
          ret_d   = S_PLAY;
          state_d = S_PAUSED;
        end
      end
      S_GAP: begin
        if (gap_exp) begin
          advance = 1'b1;
        end else if (pause) begin
          ret_d   = S_GAP;
          state_d = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (pause) state_d = ret_q;
      end
      default: state_d = S_IDLE;
    endcase

    // last address is an implicit end marker: no wrap-around
    if (advance) begin
      if (addr_q == ADDR_LAST) begin
        finish = 1'b1;
      end else begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = S_FETCH;
      end
    end

    if (finish) begin
      if (loop) begin
        addr_d  = '0;
        state_d = S_FETCH;
      end else begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end

    // stop beats start beats everything else
    if (stop) begin
      state_d = S_IDLE;
      addr_d  = '0;
      done_d  = 1'b0;
    end else if (start) begin
      state_d = S_FETCH;
      addr_d  = '0;
      cyc_d   = '0;
      tick_d  = '0;
      done_d  = 1'b0;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ret_q    <= S_IDLE;
      addr_q   <= '0;
      cyc_q    <= '0;
      tick_q   <= '0;
      dur_q    <= '0;
      nlat_q   <= '0;
      shift_q  <= '0;
      notes_q  <= '0;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      addr_q   <= addr_d;
      cyc_q    <= cyc_d;
      tick_q   <= tick_d;
      dur_q    <= dur_d;
      nlat_q   <= nlat_d;
      shift_q  <= shift_d;
      notes_q  <= (state_d == S_PLAY) ? nlat_d : 8'h00;
      busy_q   <= (state_d != S_IDLE);
      paused_q <= (state_d == S_PAUSED);
      done_q   <= done_d;
    end
  end

  assign rom_addr = addr_q;
  assign notes    = notes_q;
  assign shift    = shift_q;
  assign busy     = busy_q;
  assign paused   = paused_q;
  assign done     = done_q;

endmodule

// File: tb/tb_auto_player.sv
// tb_auto_player: two sequencer instances (gap/wide address and
// no-gap/2-bit address) checked against a song-timeline model, a table of
// control vectors, and hand sequences for pause, loop and reset.
module tb_auto_player;
  localparam int TD_A = 4, GAP_A = 1, AW_A = 4;
  localparam int TD_B = 3, GAP_B = 0, AW_B = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic st_a = 0, pa_a = 0, sp_a = 0, lp_a = 0;
  logic [AW_A-1:0] addr_a;
  logic [15:0] rd_a = '0;
  logic [7:0] notes_a;
  logic [1:0] sh_a;
  logic busy_a, paused_a, done_a;

  logic st_b = 0, pa_b = 0, sp_b = 0, lp_b = 0;
  logic [AW_B-1:0] addr_b;
  logic [15:0] rd_b = '0;
  logic [7:0] notes_b;
  logic [1:0] sh_b;
  logic busy_b, paused_b, done_b;

  logic [15:0] rom_a [16];
  logic [15:0] rom_b [4];

  always @(posedge clk) rd_a <= rom_a[addr_a];
  always @(posedge clk) rd_b <= rom_b[addr_b];

  auto_player #(.TICK_DIV(TD_A), .GAP_TICKS(GAP_A), .ADDR_W(AW_A)) u_a (
    .clk(clk), .rst_n(rst_n), .start(st_a), .pause(pa_a), .stop(sp_a), .loop(lp_a),
    .rom_addr(addr_a), .rom_data(rd_a), .notes(notes_a), .shift(sh_a),
    .busy(busy_a), .paused(paused_a), .done(done_a));

  auto_player #(.TICK_DIV(TD_B), .GAP_TICKS(GAP_B), .ADDR_W(AW_B)) u_b (
    .clk(clk), .rst_n(rst_n), .start(st_b), .pause(pa_b), .stop(sp_b), .loop(lp_b),
    .rom_addr(addr_b), .rom_data(rd_b), .notes(notes_b), .shift(sh_b),
    .busy(busy_b), .paused(paused_b), .done(done_b));

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc_a(input logic s, input logic p, input logic t);
    st_a = s; pa_a = p; sp_a = t;
    tick();
    st_a = 0; pa_a = 0; sp_a = 0;
  endtask

  // ---------------- song-timeline reference model ----------------
  typedef struct {
    logic [7:0] n;
    logic [1:0] s;
    bit cs;
    bit b;
    bit d;
  } exp_t;

  exp_t eq[$];

  function automatic exp_t mk(logic [7:0] n, logic [1:0] s, bit cs, bit b, bit d);
    exp_t e;
    e.n = n; e.s = s; e.cs = cs; e.b = b; e.d = d;
    return e;
  endfunction

  function automatic logic [15:0] romw(int dut, int a);
    return (dut == 0) ? rom_a[a] : rom_b[a];
  endfunction

  // One record per clock after the start edge: fetch, wait, note, gap, ...
  task automatic build(input int dut, input bit lp);
    int td, gp, mx, a, d;
    logic [15:0] w;
    td = (dut == 0) ? TD_A : TD_B;
    gp = (dut == 0) ? GAP_A : GAP_B;
    mx = (dut == 0) ? (1 << AW_A) - 1 : (1 << AW_B) - 1;
    eq.delete();
    a = 0;
    eq.push_back(mk(8'h00, 2'b00, 1'b0, 1'b1, 1'b0));
    while (eq.size() < 20000) begin
      eq.push_back(mk(8'h00, 2'b00, 1'b0, 1'b1, 1'b0));
      w = romw(dut, a);
      d = int'(w[5:0]);
      if (d != 0) begin
        repeat (d * td) eq.push_back(mk(w[15:8], w[7:6], 1'b1, 1'b1, 1'b0));
        repeat (gp * td) eq.push_back(mk(8'h00, w[7:6], 1'b1, 1'b1, 1'b0));
      end
      if (d != 0 && a < mx) begin
        a++;
        eq.push_back(mk(8'h00, 2'b00, 1'b0, 1'b1, 1'b0));
      end else if (lp) begin
        a = 0;
        eq.push_back(mk(8'h00, 2'b00, 1'b0, 1'b1, 1'b0));
      end else begin
        eq.push_back(mk(8'h00, 2'b00, 1'b0, 1'b0, 1'b1));
        break;
      end
    end
  endtask

  task automatic run_song(input int dut, input string nm);
    int e0;
    logic [7:0] gn;
    logic [1:0] gs;
    logic gb, gd;
    build(dut, 1'b0);
    e0 = errors;
    if (dut == 0) st_a = 1; else st_b = 1;
    tick();
    st_a = 0; st_b = 0;
    for (int i = 0; i < eq.size(); i++) begin
      if (i > 0) tick();
      gn = (dut == 0) ? notes_a : notes_b;
      gs = (dut == 0) ? sh_a : sh_b;
      gb = (dut == 0) ? busy_a : busy_b;
      gd = (dut == 0) ? done_a : done_b;
      chk($sformatf("%s_notes_c%0d", nm, i + 1), 32'(gn), 32'(eq[i].n));
      if (eq[i].cs) chk($sformatf("%s_shift_c%0d", nm, i + 1), 32'(gs), 32'(eq[i].s));
      chk($sformatf("%s_busy_c%0d", nm, i + 1), 32'(gb), 32'(eq[i].b));
      chk($sformatf("%s_done_c%0d", nm, i + 1), 32'(gd), 32'(eq[i].d));
      if (errors - e0 > 4) break;
    end
    tick();
    gb = (dut == 0) ? busy_a : busy_b;
    gd = (dut == 0) ? done_a : done_b;
    chk({nm, "_after_busy"}, 32'(gb), 32'd0);
    chk({nm, "_after_done"}, 32'(gd), 32'd0);
  endtask

  // ---------------- control-vector table ----------------
  typedef struct {
    int n;
    logic st, pa, sp;
    logic [7:0] en;
    logic eb, ep, ed, ca;
    logic [3:0] ea;
  } vec_t;

  function automatic vec_t v(int n, logic st, logic pa, logic sp, logic [7:0] en,
                             logic eb, logic ep, logic ed, logic ca, logic [3:0] ea);
    vec_t r;
    r.n = n; r.st = st; r.pa = pa; r.sp = sp; r.en = en;
    r.eb = eb; r.ep = ep; r.ed = ed; r.ca = ca; r.ea = ea;
    return r;
  endfunction

  task automatic set_basic_rom();
    for (int i = 0; i < 16; i++) rom_a[i] = 16'h0000;
    rom_a[0] = 16'h0185;
    rom_a[1] = 16'h8042;
  endtask

  initial begin
    vec_t tbl[$];
    int k, dn, bad, cnt;

    set_basic_rom();
    for (int i = 0; i < 4; i++) rom_b[i] = 16'h0000;

    // reset state
    repeat (2) tick();
    rst_n = 1;
    tick();
    chk("rst_notes_a", 32'(notes_a), 0);
    chk("rst_shift_a", 32'(sh_a), 0);
    chk("rst_busy_a", 32'(busy_a), 0);
    chk("rst_paused_a", 32'(paused_a), 0);
    chk("rst_done_a", 32'(done_a), 0);
    chk("rst_addr_a", 32'(addr_a), 0);
    chk("rst_notes_b", 32'(notes_b), 0);
    chk("rst_busy_b", 32'(busy_b), 0);
    chk("rst_paused_b", 32'(paused_b), 0);

    // table: inputs on the first cycle of each row, checks after n clocks
    //              n  st pa sp notes  busy ps dn ca addr
    tbl.push_back(v(1, 1, 0, 0, 8'h00, 1, 0, 0, 1, 0)); // start -> FETCH
    tbl.push_back(v(2, 0, 0, 0, 8'h01, 1, 0, 0, 1, 0)); // first note
    tbl.push_back(v(1, 0, 1, 0, 8'h00, 1, 1, 0, 1, 0)); // pause
    tbl.push_back(v(1, 0, 1, 0, 8'h01, 1, 0, 0, 1, 0)); // resume
    tbl.push_back(v(1, 1, 0, 0, 8'h00, 1, 0, 0, 1, 0)); // start while playing
    tbl.push_back(v(2, 0, 0, 0, 8'h01, 1, 0, 0, 1, 0));
    tbl.push_back(v(1, 0, 1, 0, 8'h00, 1, 1, 0, 1, 0)); // pause
    tbl.push_back(v(1, 1, 1, 0, 8'h00, 1, 0, 0, 1, 0)); // start beats pause
    tbl.push_back(v(2, 0, 0, 0, 8'h01, 1, 0, 0, 1, 0));
    tbl.push_back(v(20, 0, 0, 0, 8'h00, 1, 0, 0, 1, 0)); // into gap
    tbl.push_back(v(1, 0, 0, 1, 8'h00, 0, 0, 0, 1, 0)); // stop in gap
    tbl.push_back(v(3, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0)); // no done
    tbl.push_back(v(1, 1, 0, 1, 8'h00, 0, 0, 0, 1, 0)); // stop beats start
    tbl.push_back(v(1, 0, 1, 0, 8'h00, 0, 0, 0, 1, 0)); // pause in IDLE
    tbl.push_back(v(1, 1, 0, 0, 8'h00, 1, 0, 0, 1, 0));
    tbl.push_back(v(1, 0, 1, 0, 8'h00, 1, 0, 0, 1, 0)); // pause in FETCH ignored
    tbl.push_back(v(1, 0, 0, 0, 8'h01, 1, 0, 0, 1, 0));
    tbl.push_back(v(19, 0, 0, 0, 8'h01, 1, 0, 0, 1, 0)); // last note cycle
    tbl.push_back(v(1, 0, 0, 0, 8'h00, 1, 0, 0, 1, 0)); // gap
    tbl.push_back(v(4, 0, 0, 0, 8'h00, 1, 0, 0, 1, 1)); // fetch entry 1
    tbl.push_back(v(2, 0, 0, 0, 8'h80, 1, 0, 0, 1, 1));
    tbl.push_back(v(12, 0, 0, 0, 8'h00, 1, 0, 0, 1, 2)); // fetch end marker
    tbl.push_back(v(2, 0, 0, 0, 8'h00, 0, 0, 1, 0, 0)); // done
    tbl.push_back(v(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0)); // one-cycle pulse
    for (int i = 0; i < tbl.size(); i++) begin
      cyc_a(tbl[i].st, tbl[i].pa, tbl[i].sp);
      repeat (tbl[i].n - 1) tick();
      chk($sformatf("tbl%0d_notes", i), 32'(notes_a), 32'(tbl[i].en));
      chk($sformatf("tbl%0d_busy", i), 32'(busy_a), 32'(tbl[i].eb));
      chk($sformatf("tbl%0d_paused", i), 32'(paused_a), 32'(tbl[i].ep));
      chk($sformatf("tbl%0d_done", i), 32'(done_a), 32'(tbl[i].ed));
      if (tbl[i].ca) chk($sformatf("tbl%0d_addr", i), 32'(addr_a), 32'(tbl[i].ea));
    end

    // pause 6 cycles into note 0, hold 50, resume: 14 cycles remain
    cyc_a(1, 0, 0);
    repeat (7) tick();
    chk("pause_pre_note", 32'(notes_a), 32'h01);
    cyc_a(0, 1, 0);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (notes_a !== 8'h00 || paused_a !== 1'b1 || busy_a !== 1'b1) bad++;
      if (i < 49) tick();
    end
    chk("pause_hold_bad_cycles", 32'(bad), 0);
    cyc_a(0, 1, 0);
    chk("pause_resumed_flag", 32'(paused_a), 0);
    cnt = 0;
    while (notes_a === 8'h01 && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("pause_remaining_cycles", 32'(cnt), 14);
    chk("pause_then_gap", 32'(notes_a), 0);
    cnt = 0;
    while (busy_a === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    chk("pause_song_end", 32'(busy_a), 0);

    // loop: end marker refetches entry 0; dropping loop gives done
    lp_a = 1;
    cyc_a(1, 0, 0);
    dn = 0;
    for (k = 1; k < 45; k++) begin
      if (done_a === 1'b1) dn++;
      if (k == 42) chk("loop_wait_addr", 32'(addr_a), 2);
      if (k == 43) chk("loop_refetch_addr", 32'(addr_a), 0);
      tick();
    end
    chk("loop_replay_note", 32'(notes_a), 32'h01);
    chk("loop_no_done", 32'(dn), 0);
    lp_a = 0;
    while (done_a !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    chk("loop_done_cycle", 32'(k), 85);
    chk("loop_done_busy", 32'(busy_a), 0);
    tick();
    chk("loop_done_pulse", 32'(done_a), 0);

    // model-checked songs
    run_song(0, "basicA");
    rom_b[0] = 16'h1141; rom_b[1] = 16'h2202; rom_b[2] = 16'h4483; rom_b[3] = 16'h8801;
    run_song(1, "fullB");
    for (int r = 0; r < 6; r++) begin
      int len;
      len = $urandom_range(1, 5);
      for (int i = 0; i < 16; i++) rom_a[i] = 16'h0000;
      for (int i = 0; i < len; i++)
        rom_a[i] = {8'($urandom), 2'($urandom_range(0, 2)), 6'($urandom_range(1, 3))};
      run_song(0, $sformatf("randA%0d", r));
    end
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 4; i++)
        rom_b[i] = {8'($urandom), 2'($urandom_range(0, 2)), 6'($urandom_range(1, 3))};
      if ($urandom_range(0, 1) == 1) rom_b[$urandom_range(0, 3)] = {8'($urandom), 8'h00};
      run_song(1, $sformatf("randB%0d", r));
    end

    // asynchronous reset in the middle of a note
    set_basic_rom();
    cyc_a(1, 0, 0);
    repeat (4) tick();
    chk("arst_pre_note", 32'(notes_a), 32'h01);
    chk("arst_pre_shift", 32'(sh_a), 32'h2);
    #1 rst_n = 0;
    #1;
    chk("arst_notes", 32'(notes_a), 0);
    chk("arst_shift", 32'(sh_a), 0);
    chk("arst_busy", 32'(busy_a), 0);
    @(negedge clk);
    tick();
    rst_n = 1;
    repeat (3) tick();
    chk("arst_idle_busy", 32'(busy_a), 0);
    chk("arst_idle_notes", 32'(notes_a), 0);
    chk("arst_idle_addr", 32'(addr_a), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
